// File: rtl/xsp_pkg.sv
// Shared definitions for the XSP cipher engine: mode encoding, FSM states
// and the width-generic bit manipulation helpers used by the round logic.
package xsp_pkg;

  // Helpers work on a fixed 64-bit container. The live width is passed
  // in, so the engine supports any even WIDTH from 4 up to 64.
  localparam int MAX_W = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [MAX_W-1:0] word_t;

  // Rotate the low w bits of x left by n (n taken mod w); upper bits return 0.
  function automatic word_t rotl(input word_t x, input int n, input int w);
    word_t r;
    int    s;
    r = '0;
    s = n % w;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < w) r[(b + s) % w] = x[b];
    end
    return r;
  endfunction

  // Rotate right expressed as the complementary left rotation.
  function automatic word_t rotr(input word_t x, input int n, input int w);
    return rotl(x, w - (n % w), w);
  endfunction

  // Exchanging the two halves of an even-width word is a rotation by w/2.
  function automatic word_t swap_halves(input word_t x, input int w);
    return rotl(x, w / 2, w);
  endfunction

  // rk_i = rotl(key, i mod w) XOR i, with i truncated to w bits.
  function automatic word_t round_key(input word_t key, input int i, input int w);
    word_t iv;
    iv = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < w) iv[b] = i[b];
    end
    return rotl(key, i % w, w) ^ iv;
  endfunction

endpackage

// File: rtl/xsp_cipher_engine_if.sv
// Stream bundle between the XSP engine and its source/sink.
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. A source holds valid and its payload stable until
// that edge; ready may depend on state only, never on valid.
interface xsp_cipher_engine_if
  import xsp_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_key;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_mode;
  logic             busy;
  state_t           dbg_state;

  modport master (
    output in_valid, in_data, in_key, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_data, in_key, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode, busy, dbg_state
  );
endinterface

// File: rtl/xsp_round.sv
// One combinational XSP round. Encrypt: P(rotl(x ^ rk, SHIFT)).
// Decrypt is the exact inverse: rotr(P(x), SHIFT) ^ rk.
module xsp_round
  import xsp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] rk,
  input  logic             mode,
  output logic [WIDTH-1:0] x_next
);

  // Select the forward or inverse round on the live mode bit.
  always_comb begin
    x_next = '0;
    if (mode == MODE_DEC) begin
      x_next = WIDTH'(rotr(swap_halves(word_t'(x), WIDTH), SHIFT, WIDTH) ^ word_t'(rk));
    end else begin
      x_next = WIDTH'(swap_halves(rotl(word_t'(x) ^ word_t'(rk), SHIFT, WIDTH), WIDTH));
    end
  end

endmodule

// File: rtl/xsp_cipher_engine.sv
// Iterative XSP cipher: accepts one block in IDLE, runs ROUNDS rounds at
// one per clock in RUN, then presents the result in DONE until taken.
// WIDTH must be even and 4..64; ROUNDS 1..255; SHIFT 1..WIDTH-1.
module xsp_cipher_engine
  import xsp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROUNDS = 4,
  parameter int SHIFT  = 3
) (
  input logic clk,
  input logic rst,
  xsp_cipher_engine_if.slave bus
);

  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] x_q, key_q, out_data_q;
  logic             mode_q, out_mode_q;
  logic             accept, last_round;
  logic [WIDTH-1:0] rk, x_next;

  // Round key for the round index currently held in the counter.
  always_comb begin
    rk = WIDTH'(round_key(word_t'(key_q), int'(cnt_q), WIDTH));
  end

  xsp_round #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_round (
    .x      (x_q),
    .rk     (rk),
    .mode   (mode_q),
    .x_next (x_next)
  );

  // Next-state logic. Encrypt counts up and ends at LAST_IDX; decrypt
  // walks the keys backwards and ends at index 0.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_round = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        last_round = (mode_q == MODE_ENC) ? (cnt_q == LAST_IDX) : (cnt_q == 8'd0);
        if (last_round) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: latch the block on acceptance, apply one round per RUN
  // cycle, and capture the result on the final round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      x_q        <= '0;
      key_q      <= '0;
      mode_q     <= MODE_ENC;
      out_data_q <= '0;
      out_mode_q <= MODE_ENC;
    end else if (accept) begin
      x_q    <= bus.in_data;
      key_q  <= bus.in_key;
      mode_q <= bus.in_mode;
      cnt_q  <= (bus.in_mode == MODE_DEC) ? LAST_IDX : 8'd0;
    end else if (state_q == RUN) begin
      x_q <= x_next;
      if (last_round) begin
        out_data_q <= x_next;
        out_mode_q <= mode_q;
      end else if (mode_q == MODE_ENC) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out_data  = out_data_q;
    bus.out_mode  = out_mode_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_xsp_cipher_engine.sv
// Bench for xsp_cipher_engine: four instances (W8/R1, W8/R2, W8/R4, W16/R8)
// driven by tasks, checked by one monitor against per-instance queues.
module tb_xsp_cipher_engine;
  import xsp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        iv[4], im[4], ir[4], ov[4], om[4], ordy[4], bsy[4], pv[4];
  logic [15:0] idat[4], ik[4], od[4];
  int          ordy_mode[4];
  logic [16:0] exp_q[4][$];
  int          acc_q[4][$];
  int          hs[4];
  int          last_acc[4];

  function automatic int rn(input int id);
    case (id)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  // ---------------- DUTs ----------------
  xsp_cipher_engine_if #(.WIDTH(8))  if_a ();
  xsp_cipher_engine_if #(.WIDTH(8))  if_b ();
  xsp_cipher_engine_if #(.WIDTH(8))  if_c ();
  xsp_cipher_engine_if #(.WIDTH(16)) if_d ();

  xsp_cipher_engine #(.WIDTH(8),  .ROUNDS(1), .SHIFT(3)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  xsp_cipher_engine #(.WIDTH(8),  .ROUNDS(2), .SHIFT(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  xsp_cipher_engine #(.WIDTH(8),  .ROUNDS(4), .SHIFT(3)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  xsp_cipher_engine #(.WIDTH(16), .ROUNDS(8), .SHIFT(3)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

  assign if_a.in_valid = iv[0];  assign if_a.in_data = idat[0][7:0];  assign if_a.in_key = ik[0][7:0];
  assign if_a.in_mode = im[0];   assign if_a.out_ready = ordy[0];
  assign ir[0] = if_a.in_ready;  assign ov[0] = if_a.out_valid;  assign od[0] = {8'h00, if_a.out_data};
  assign om[0] = if_a.out_mode;  assign bsy[0] = if_a.busy;

  assign if_b.in_valid = iv[1];  assign if_b.in_data = idat[1][7:0];  assign if_b.in_key = ik[1][7:0];
  assign if_b.in_mode = im[1];   assign if_b.out_ready = ordy[1];
  assign ir[1] = if_b.in_ready;  assign ov[1] = if_b.out_valid;  assign od[1] = {8'h00, if_b.out_data};
  assign om[1] = if_b.out_mode;  assign bsy[1] = if_b.busy;

  assign if_c.in_valid = iv[2];  assign if_c.in_data = idat[2][7:0];  assign if_c.in_key = ik[2][7:0];
  assign if_c.in_mode = im[2];   assign if_c.out_ready = ordy[2];
  assign ir[2] = if_c.in_ready;  assign ov[2] = if_c.out_valid;  assign od[2] = {8'h00, if_c.out_data};
  assign om[2] = if_c.out_mode;  assign bsy[2] = if_c.busy;

  assign if_d.in_valid = iv[3];  assign if_d.in_data = idat[3];  assign if_d.in_key = ik[3];
  assign if_d.in_mode = im[3];   assign if_d.out_ready = ordy[3];
  assign ir[3] = if_d.in_ready;  assign ov[3] = if_d.out_valid;  assign od[3] = if_d.out_data;
  assign om[3] = if_d.out_mode;  assign bsy[3] = if_d.busy;

  // ---------------- reference model ----------------
  function automatic int unsigned m_mask(input int w);
    return (32'h1 << w) - 1;
  endfunction

  function automatic int unsigned m_rotl(input int unsigned x, input int n, input int w);
    int k;
    k = n % w;
    if (k == 0) return x & m_mask(w);
    return ((x << k) | (x >> (w - k))) & m_mask(w);
  endfunction

  function automatic int unsigned m_enc(input int unsigned d, input int unsigned k,
                                        input int r, input int s, input int w);
    int unsigned x, rkv;
    x = d;
    for (int i = 0; i < r; i++) begin
      rkv = m_rotl(k, i % w, w) ^ (i & m_mask(w));
      x   = m_rotl(m_rotl(x ^ rkv, s, w), w / 2, w);
    end
    return x;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input int unsigned d, input int unsigned k,
                       input logic m, input int unsigned e);
    int t;
    t = 0;
    @(negedge clk);
    iv[id] = 1'b1; idat[id] = d[15:0]; ik[id] = k[15:0]; im[id] = m;
    while (!ir[id] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ir[id]) begin
      check($sformatf("accept_timeout%0d", id), 0, 1);
      iv[id] = 1'b0;
    end else begin
      exp_q[id].push_back({m, e[15:0]});
      acc_q[id].push_back(cyc + 1);
      last_acc[id] = cyc + 1;
      @(posedge clk);
      #1;
      iv[id] = 1'b0;
      idat[id] = 16'($urandom);
      ik[id] = 16'($urandom);
      im[id] = 1'($urandom);
    end
  endtask

  task automatic wait_idle(input int id);
    int t;
    t = 0;
    while ((exp_q[id].size() != 0 || acc_q[id].size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain%0d", id), exp_q[id].size() + acc_q[id].size(), 0);
  endtask

  // out_ready per instance: 0 = held high, 1 = held low, 2 = random.
  initial begin
    for (int j = 0; j < 4; j++) ordy[j] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
        if (ordy_mode[j] == 0)      ordy[j] = 1'b1;
        else if (ordy_mode[j] == 1) ordy[j] = 1'b0;
        else                        ordy[j] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [16:0] e;
    int a;
    for (int j = 0; j < 4; j++) begin
      if (!rst) begin
        if (ov[j] && !pv[j]) begin
          if (acc_q[j].size() == 0) check($sformatf("unexpected_valid%0d", j), 1, 0);
          else begin
            a = acc_q[j].pop_front();
            check($sformatf("latency%0d", j), cyc - a, rn(j));
          end
        end
        if (ov[j] && ordy[j]) begin
          hs[j]++;
          if (exp_q[j].size() == 0) check($sformatf("unexpected_output%0d", j), 1, 0);
          else begin
            e = exp_q[j].pop_front();
            check($sformatf("data%0d", j), od[j], e[15:0]);
            check($sformatf("mode%0d", j), om[j], e[16]);
          end
        end
      end
      pv[j] <= ov[j];
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #50000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned d, k, e;
    int t, h, a1, seen;
    int unsigned vals[3];
    for (int j = 0; j < 4; j++) begin
      iv[j] = 1'b0; idat[j] = '0; ik[j] = '0; im[j] = 1'b0;
      ordy_mode[j] = 0; hs[j] = 0; last_acc[j] = 0; pv[j] = 1'b0;
    end

    // Reset values while reset is held.
    #22;
    check("rst_in_ready", ir[2], 1);
    check("rst_out_valid", ov[2], 0);
    check("rst_busy", bsy[2], 0);
    check("rst_out_data", od[2], 0);
    check("rst_out_mode", om[2], 0);
    check("rst_state", if_c.dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the small configurations.
    drive(0, 'h01, 'h00, MODE_ENC, 'h80);
    wait_idle(0);
    drive(1, 'h00, 'h01, MODE_ENC, 'hC1);
    drive(1, 'hC1, 'h01, MODE_DEC, 'h00);
    wait_idle(1);

    // Throughput with out_ready high: accepts ROUNDS+2 cycles apart.
    drive(2, 'h3C, 'h5A, MODE_ENC, m_enc('h3C, 'h5A, 4, 3, 8));
    a1 = last_acc[2];
    drive(2, 'hC3, 'hA5, MODE_ENC, m_enc('hC3, 'hA5, 4, 3, 8));
    check("throughput", last_acc[2] - a1, 6);
    wait_idle(2);

    // Backpressure: DONE holds, inputs ignored, one transfer on release.
    ordy_mode[2] = 1;
    d = $urandom_range(0, 255); k = $urandom_range(0, 255);
    e = m_enc(d, k, 4, 3, 8);
    drive(2, d, k, MODE_ENC, e);
    t = 0;
    while (!ov[2] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid", ov[2], 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", od[2], e);
      check("bp_in_ready_low", ir[2], 0);
      iv[2] = 1'($urandom_range(0, 1));
      idat[2] = 16'($urandom);
    end
    iv[2] = 1'b0;
    h = hs[2];
    ordy_mode[2] = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_single_transfer", hs[2] - h, 1);
    check("bp_in_ready_after", ir[2], 1);
    check("bp_valid_after", ov[2], 0);

    // Reset in the middle of RUN discards the block.
    d = $urandom_range(0, 255); k = $urandom_range(0, 255);
    drive(2, d, k, MODE_ENC, m_enc(d, k, 4, 3, 8));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", ir[2], 1);
    check("mid_rst_out_valid", ov[2], 0);
    check("mid_rst_busy", bsy[2], 0);
    check("mid_rst_out_data", od[2], 0);
    check("mid_rst_out_mode", om[2], 0);
    exp_q[2].delete();
    acc_q[2].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[2]) seen++;
    end
    check("mid_rst_no_output", seen, 0);
    drive(2, 'h01, 'hFF, MODE_ENC, m_enc('h01, 'hFF, 4, 3, 8));
    wait_idle(2);

    // Random round trips with random sink stalls and source gaps.
    ordy_mode[2] = 2;
    for (int n = 0; n < 1000; n++) begin
      d = $urandom_range(0, 255);
      k = $urandom_range(0, 255);
      e = m_enc(d, k, 4, 3, 8);
      drive(2, d, k, MODE_ENC, e);
      drive(2, e, k, MODE_DEC, d);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    ordy_mode[2] = 0;
    wait_idle(2);

    // Wide configuration round trips.
    vals[0] = 'hFFFF; vals[1] = 'h0000; vals[2] = 'hA5A5;
    for (int n = 0; n < 3; n++) begin
      e = m_enc(vals[n], 'h1234, 8, 3, 16);
      drive(3, vals[n], 'h1234, MODE_ENC, e);
      drive(3, e, 'h1234, MODE_DEC, vals[n]);
    end
    wait_idle(3);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
